// File: rtl/player_ctl_1_if.sv
// VGA timing bus as seen by the player controller; only vertical blanking is carried.
interface vga_if;
  logic vblnk;

  modport in  (input  vblnk);
  modport out (output vblnk);
endinterface

// File: rtl/player_ctl_1.sv
// Level-1 player motion controller: per-frame x step with saturation, pose state
// and a single-shot ground/rising/falling jump, all updated at the start of vblank.
module player_ctl_1 #(
  parameter int unsigned X_INIT      = 380,
  parameter int unsigned X_MIN       = 0,
  parameter int unsigned X_MAX       = 760,
  parameter int unsigned X_STEP      = 4,
  parameter int unsigned JUMP_HEIGHT = 96,
  parameter int unsigned JUMP_STEP   = 6
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vga_in,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  output logic [11:0] xpos_player1,
  output logic [11:0] ypos_player1,
  output logic [1:0]  state,
  output logic        jumping
);

  typedef enum logic [1:0] {
    IDLE1  = 2'd0,
    RIGHT1 = 2'd1,
    LEFT1  = 2'd2
  } pose_t;

  typedef enum logic [1:0] {
    GROUND,
    RISING,
    FALLING
  } jump_t;

  localparam logic [12:0] XMIN13  = 13'(X_MIN);
  localparam logic [12:0] XMAX13  = 13'(X_MAX);
  localparam logic [12:0] XSTEP13 = 13'(X_STEP);
  localparam logic [12:0] JH13    = 13'(JUMP_HEIGHT);
  localparam logic [12:0] JS13    = 13'(JUMP_STEP);
  localparam logic [11:0] X_RST   = 12'(X_INIT);
  localparam logic [11:0] Y_FIRST = 12'((JUMP_STEP < JUMP_HEIGHT) ? JUMP_STEP : JUMP_HEIGHT);

  pose_t       pose;
  jump_t       jstate;
  logic        armed;
  logic        vblnk_d;
  logic        tick;
  logic [12:0] x_inc;
  logic [12:0] y_inc;
  logic [11:0] x_dec;
  logic [11:0] y_dec;

  always_comb begin
    tick  = vga_in.vblnk & ~vblnk_d;
    x_inc = {1'b0, xpos_player1} + XSTEP13;
    x_dec = xpos_player1 - 12'(X_STEP);
    y_inc = {1'b0, ypos_player1} + JS13;
    y_dec = ypos_player1 - 12'(JUMP_STEP);
  end

  assign state = pose;

  // vblnk_d resets high so a reset released during vblank cannot fake a frame tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_d      <= 1'b1;
      xpos_player1 <= X_RST;
      ypos_player1 <= '0;
      pose         <= IDLE1;
      jstate       <= GROUND;
      jumping      <= 1'b0;
      armed        <= 1'b1;
    end else begin
      vblnk_d <= vga_in.vblnk;
      if (tick) begin
        if (btn_left && !btn_right) begin
          pose         <= LEFT1;
          xpos_player1 <= ({1'b0, xpos_player1} < XMIN13 + XSTEP13) ? XMIN13[11:0] : x_dec;
        end else if (btn_right && !btn_left) begin
          pose         <= RIGHT1;
          xpos_player1 <= (x_inc > XMAX13) ? XMAX13[11:0] : x_inc[11:0];
        end else begin
          pose <= IDLE1;
        end

        case (jstate)
          GROUND: begin
            if (btn_jump && armed) begin
              jstate       <= RISING;
              jumping      <= 1'b1;
              ypos_player1 <= Y_FIRST;
              armed        <= 1'b0;
            end else begin
              ypos_player1 <= '0;
            end
          end
          RISING: begin
            if (y_inc >= JH13) begin
              ypos_player1 <= JH13[11:0];
              jstate       <= FALLING;
            end else begin
              ypos_player1 <= y_inc[11:0];
            end
          end
          FALLING: begin
            if ({1'b0, ypos_player1} <= JS13) begin
              ypos_player1 <= '0;
              jstate       <= GROUND;
              jumping      <= 1'b0;
            end else begin
              ypos_player1 <= y_dec;
            end
          end
          default: begin
            jstate  <= GROUND;
            jumping <= 1'b0;
          end
        endcase

        if (!btn_jump) armed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_player_ctl_1.sv
// Bench for player_ctl_1: directed scenarios plus random frames checked against a
// frame-level model that replays precomputed jump trajectories.
module tb_player_ctl_1;

  localparam int XI = 380;
  localparam int XMN = 0;
  localparam int XMX = 760;
  localparam int XS = 4;
  localparam int JH = 96;
  localparam int JS = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_jump = 1'b0;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [1:0]  st;
  logic        jmp;

  vga_if vif();

  player_ctl_1 #(
    .X_INIT(XI), .X_MIN(XMN), .X_MAX(XMX), .X_STEP(XS),
    .JUMP_HEIGHT(JH), .JUMP_STEP(JS)
  ) dut (
    .clk(clk), .rst(rst), .vga_in(vif),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .xpos_player1(xpos), .ypos_player1(ypos), .state(st), .jumping(jmp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // frame-level model: pose 0=IDLE1 1=RIGHT1 2=LEFT1
  int m_x, m_pose, m_y;
  bit m_jump, m_armed;
  int jq[$];

  task automatic model_reset();
    m_x = XI; m_pose = 0; m_y = 0; m_jump = 0; m_armed = 1;
    jq.delete();
  endtask

  task automatic model_tick(input bit l, input bit r, input bit j);
    int v;
    if (l && !r) begin
      m_pose = 2;
      m_x = (m_x - XS < XMN) ? XMN : m_x - XS;
    end else if (r && !l) begin
      m_pose = 1;
      m_x = (m_x + XS > XMX) ? XMX : m_x + XS;
    end else begin
      m_pose = 0;
    end
    if (jq.size() == 0 && j && m_armed) begin
      m_armed = 0;
      v = (JS < JH) ? JS : JH;
      jq.push_back(v);
      forever begin
        v = v + JS;
        if (v >= JH) begin v = JH; jq.push_back(v); break; end
        jq.push_back(v);
      end
      forever begin
        if (v <= JS) begin jq.push_back(0); break; end
        v = v - JS;
        jq.push_back(v);
      end
    end
    if (jq.size() > 0) begin
      m_y = jq.pop_front();
      m_jump = (jq.size() > 0);
    end else begin
      m_y = 0;
    end
    if (!j) m_armed = 1;
  endtask

  // one frame: vblnk low for lo cycles then high for hi cycles; one tick at the rise
  task automatic frame(input bit l, input bit r, input bit j, input int lo, input int hi);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j;
    vif.vblnk = 1'b0;
    repeat (lo) @(negedge clk);
    vif.vblnk = 1'b1;
    model_tick(l, r, j);
    repeat (hi) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; vif.vblnk = 1'b1; btn_right = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({xpos, ypos, st, jmp} !== {12'd380, 12'd0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got x=%0d y=%0d st=%0d j=%0b want 380 0 0 0", xpos, ypos, st, jmp);
    end
    rst = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if ({xpos, ypos, st, jmp} !== {12'd380, 12'd0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL release_vblnk_high got x=%0d y=%0d st=%0d j=%0b want 380 0 0 0", xpos, ypos, st, jmp);
    end
    frame(0, 1, 0, 2, 2);
    total++;
    if ({xpos, st} !== {12'd384, 2'd1}) begin
      bad++;
      $display("FAIL first_tick got x=%0d st=%0d want 384 1", xpos, st);
    end
  endtask

  task automatic test_right();
    frame(0, 1, 0, 2, 2);
    frame(0, 1, 0, 2, 2);
    total++;
    if ({xpos, st} !== {12'd392, 2'd1}) begin
      bad++;
      $display("FAIL right_3 got x=%0d st=%0d want 392 1", xpos, st);
    end
    for (int i = 0; i < 100; i++) begin
      frame(0, 1, 0, 1, 2);
      total++;
      if ({xpos, ypos, st, jmp} !== {12'(m_x), 12'(m_y), 2'(m_pose), m_jump}) begin
        bad++;
        $display("FAIL right_sat[%0d] got x=%0d st=%0d want x=%0d st=%0d", i, xpos, st, m_x, m_pose);
      end
    end
    total++;
    if (xpos !== 12'd760) begin
      bad++;
      $display("FAIL right_limit got x=%0d want 760", xpos);
    end
  endtask

  task automatic test_left();
    for (int i = 0; i < 200; i++) begin
      frame(1, 0, 0, 1, 2);
      total++;
      if ({xpos, ypos, st, jmp} !== {12'(m_x), 12'(m_y), 2'(m_pose), m_jump}) begin
        bad++;
        $display("FAIL left_sat[%0d] got x=%0d st=%0d want x=%0d st=%0d", i, xpos, st, m_x, m_pose);
      end
    end
    total++;
    if ({xpos, st} !== {12'd0, 2'd2}) begin
      bad++;
      $display("FAIL left_limit got x=%0d st=%0d want 0 2", xpos, st);
    end
    repeat (3) frame(0, 1, 0, 2, 2);
    frame(1, 1, 0, 2, 2);
    total++;
    if ({xpos, st} !== {12'd12, 2'd0}) begin
      bad++;
      $display("FAIL both_pressed got x=%0d st=%0d want 12 0", xpos, st);
    end
  endtask

  task automatic test_jump_held();
    int air_dut = 0;
    int air_mdl = 0;
    for (int i = 0; i < 40; i++) begin
      frame(0, 0, 1, 2, 2);
      if (jmp === 1'b1) air_dut++;
      if (m_jump) air_mdl++;
      total++;
      if ({ypos, jmp} !== {12'(m_y), m_jump}) begin
        bad++;
        $display("FAIL jump_held[%0d] got y=%0d j=%0b want y=%0d j=%0b", i, ypos, jmp, m_y, m_jump);
      end
      if (i == 15) begin
        total++;
        if (ypos !== 12'd96) begin
          bad++;
          $display("FAIL jump_apex got y=%0d want 96", ypos);
        end
      end
    end
    total++;
    if (air_dut != air_mdl) begin
      bad++;
      $display("FAIL jump_air_frames got %0d want %0d", air_dut, air_mdl);
    end
    total++;
    if ({ypos, jmp} !== {12'd0, 1'b0}) begin
      bad++;
      $display("FAIL no_rejump got y=%0d j=%0b want 0 0", ypos, jmp);
    end
    frame(0, 0, 0, 2, 2);
    frame(0, 0, 1, 2, 2);
    total++;
    if ({ypos, jmp} !== {12'd6, 1'b1}) begin
      bad++;
      $display("FAIL rejump got y=%0d j=%0b want 6 1", ypos, jmp);
    end
    repeat (35) frame(0, 0, 0, 1, 1);
  endtask

  task automatic test_combined();
    logic [11:0] prev_x;
    for (int i = 0; i < 10; i++) begin
      prev_x = xpos;
      frame(0, 1, 1, 2, 2);
      total++;
      if ({xpos, ypos, st, jmp} !== {12'(m_x), 12'(m_y), 2'(m_pose), m_jump} || xpos <= prev_x) begin
        bad++;
        $display("FAIL jump_right[%0d] got x=%0d y=%0d want x=%0d y=%0d", i, xpos, ypos, m_x, m_y);
      end
    end
    // left pulses that fall only between ticks
    @(negedge clk);
    btn_right = 1'b0; btn_jump = 1'b0; vif.vblnk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      btn_left = ~btn_left;
    end
    btn_left = 1'b0;
    vif.vblnk = 1'b1;
    model_tick(0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      btn_left = ~btn_left;
      @(negedge clk);
    end
    btn_left = 1'b0;
    total++;
    if ({xpos, ypos, st, jmp} !== {12'(m_x), 12'(m_y), 2'(m_pose), m_jump}) begin
      bad++;
      $display("FAIL toggle_between_ticks got x=%0d st=%0d want x=%0d st=%0d", xpos, st, m_x, m_pose);
    end
    frame(0, 1, 0, 3, 1000);
    total++;
    if ({xpos, ypos, st, jmp} !== {12'(m_x), 12'(m_y), 2'(m_pose), m_jump}) begin
      bad++;
      $display("FAIL long_vblank got x=%0d want x=%0d", xpos, m_x);
    end
    repeat (30) frame(0, 0, 0, 1, 1);
  endtask

  task automatic test_reset_mid_jump();
    frame(0, 0, 0, 2, 2);
    for (int i = 0; i < 20 && m_y != 48; i++) frame(0, 0, 1, 2, 2);
    total++;
    if ({ypos, jmp} !== {12'd48, 1'b1}) begin
      bad++;
      $display("FAIL mid_jump_setup got y=%0d j=%0b want 48 1", ypos, jmp);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    total++;
    if ({xpos, ypos, st, jmp} !== {12'd380, 12'd0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_jump got x=%0d y=%0d st=%0d j=%0b want 380 0 0 0", xpos, ypos, st, jmp);
    end
    btn_right = 1'b1; btn_jump = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({xpos, ypos, st, jmp} !== {12'd380, 12'd0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL post_reset_hold got x=%0d y=%0d st=%0d j=%0b want 380 0 0 0", xpos, ypos, st, jmp);
    end
    frame(0, 1, 1, 2, 2);
    total++;
    if ({xpos, ypos, st, jmp} !== {12'(m_x), 12'(m_y), 2'(m_pose), m_jump}) begin
      bad++;
      $display("FAIL post_reset_tick got x=%0d y=%0d want x=%0d y=%0d", xpos, ypos, m_x, m_y);
    end
  endtask

  task automatic test_random();
    bit l, r, j;
    for (int i = 0; i < 300; i++) begin
      l = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      j = ($urandom_range(0, 3) != 0);
      frame(l, r, j, $urandom_range(1, 4), $urandom_range(1, 6));
      total++;
      if ({xpos, ypos, st, jmp} !== {12'(m_x), 12'(m_y), 2'(m_pose), m_jump}) begin
        bad++;
        $display("FAIL random[%0d] got x=%0d y=%0d st=%0d j=%0b want x=%0d y=%0d st=%0d j=%0b",
                 i, xpos, ypos, st, jmp, m_x, m_y, m_pose, m_jump);
      end
    end
  endtask

  initial begin
    vif.vblnk = 1'b1;
    test_reset();
    test_right();
    test_left();
    test_jump_held();
    test_combined();
    test_reset_mid_jump();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
